// File: rtl/escalonador_pkg.sv
// Shared definitions for the active-node selection sequencer:
// FSM encoding, default sizes and the watchdog limit.
package escalonador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_CLASSIFY    = 3'd1,
        ST_WAIT_PRONTO = 3'd2,
        ST_SCAN        = 3'd3,
        ST_GRANT       = 3'd4
    } estado_t;

    localparam int NUM_NA_PADRAO         = 8;
    localparam int CRITERIO_WIDTH_PADRAO = 5;

    // Number of WAIT_PRONTO cycles tolerated before the round is declared stalled.
    function automatic int limite_watchdog(input int num_na);
        return 2 * num_na - 1;
    endfunction

endpackage

// File: rtl/escalonador_ativos.sv
// Launches a classification round, then scans the active nodes round-robin for the
// one holding the classifier's minimum criterion and offers it with a valid/ack handshake.
module escalonador_ativos
    import escalonador_pkg::*;
#(
    parameter int NUM_NA         = NUM_NA_PADRAO,
    parameter int CRITERIO_WIDTH = CRITERIO_WIDTH_PADRAO,
    parameter int IDX_WIDTH      = $clog2(NUM_NA)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start_in,
    input  logic [NUM_NA-1:0]                na_ativo_in,
    input  logic [NUM_NA*CRITERIO_WIDTH-1:0] na_criterio_in,
    input  logic                             ca_pronto_in,
    input  logic [CRITERIO_WIDTH-1:0]        ca_criterio_geral_in,
    output logic                             aa_atualizar_o,
    output logic                             sel_valid_o,
    output logic [IDX_WIDTH-1:0]             sel_idx_o,
    output logic [CRITERIO_WIDTH-1:0]        sel_criterio_o,
    input  logic                             sel_ack_in,
    output logic                             vazio_o,
    output logic                             erro_o,
    output logic                             busy_o
);

    localparam int                   WD_WIDTH = $clog2(2 * NUM_NA);
    localparam logic [IDX_WIDTH-1:0] IDX_MAX  = IDX_WIDTH'(NUM_NA - 1);
    // The counter reaches the limit on the same edge that raises erro_o.
    localparam logic [WD_WIDTH-1:0]  WD_FIM   = WD_WIDTH'(limite_watchdog(NUM_NA) - 1);

    estado_t                   r_estado;
    estado_t                   w_prox;
    logic [WD_WIDTH-1:0]       r_wd;
    logic [IDX_WIDTH-1:0]      r_scan_cnt;
    logic [IDX_WIDTH-1:0]      r_ptr;
    logic [IDX_WIDTH-1:0]      r_last_idx;
    logic [CRITERIO_WIDTH-1:0] r_min;
    logic [IDX_WIDTH-1:0]      r_sel_idx;
    logic [CRITERIO_WIDTH-1:0] r_sel_criterio;
    logic                      r_vazio;
    logic                      r_erro;

    logic                      w_vazio_set;
    logic                      w_erro_set;
    logic                      w_wd_clr;
    logic                      w_wd_inc;
    logic                      w_carregar;
    logic                      w_avancar;
    logic                      w_grant;
    logic                      w_ack;
    logic                      w_match;

    logic [CRITERIO_WIDTH-1:0] w_criterio [NUM_NA];

    for (genvar gi = 0; gi < NUM_NA; gi++) begin : g_unpack
        assign w_criterio[gi] = na_criterio_in[CRITERIO_WIDTH*gi +: CRITERIO_WIDTH];
    end

    // Explicit wrap so non-power-of-two slot counts stay in range.
    function automatic logic [IDX_WIDTH-1:0] prox_idx(input logic [IDX_WIDTH-1:0] idx);
        return (idx == IDX_MAX) ? '0 : idx + 1'b1;
    endfunction

    assign w_match = na_ativo_in[r_ptr] && (w_criterio[r_ptr] == r_min);

    // NOTE: state and data registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        w_prox      = r_estado;
        w_vazio_set = 1'b0;
        w_erro_set  = 1'b0;
        w_wd_clr    = 1'b0;
        w_wd_inc    = 1'b0;
        w_carregar  = 1'b0;
        w_avancar   = 1'b0;
        w_grant     = 1'b0;
        w_ack       = 1'b0;
        unique case (r_estado)
            ST_IDLE: begin
                if (start_in) begin
                    if (na_ativo_in == '0) begin
                        w_vazio_set = 1'b1;
                    end else begin
                        w_prox = ST_CLASSIFY;
                    end
                end
            end
            ST_CLASSIFY: begin
                w_wd_clr = 1'b1;
                w_prox   = ST_WAIT_PRONTO;
            end
            ST_WAIT_PRONTO: begin
                w_wd_inc = 1'b1;
                if (ca_pronto_in) begin
                    w_carregar = 1'b1;
                    w_prox     = ST_SCAN;
                end else if (r_wd == WD_FIM) begin
                    w_erro_set = 1'b1;
                    w_prox     = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (w_match) begin
                    w_grant = 1'b1;
                    w_prox  = ST_GRANT;
                end else if (r_scan_cnt == IDX_MAX) begin
                    w_erro_set = 1'b1;
                    w_prox     = ST_IDLE;
                end else begin
                    w_avancar = 1'b1;
                end
            end
            ST_GRANT: begin
                if (sel_ack_in) begin
                    w_ack  = 1'b1;
                    w_prox = ST_IDLE;
                end
            end
            default: w_prox = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd           <= '0;
            r_scan_cnt     <= '0;
            r_ptr          <= '0;
            r_last_idx     <= IDX_MAX;
            r_min          <= '1;
            r_sel_idx      <= '0;
            r_sel_criterio <= '0;
            r_vazio        <= 1'b0;
            r_erro         <= 1'b0;
        end else begin
            r_vazio <= w_vazio_set;
            r_erro  <= w_erro_set;

            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 1'b1;
            end

            // Round-robin: the scan starts just past the last acknowledged winner.
            if (w_carregar) begin
                r_min      <= ca_criterio_geral_in;
                r_ptr      <= prox_idx(r_last_idx);
                r_scan_cnt <= '0;
            end else if (w_avancar) begin
                r_ptr      <= prox_idx(r_ptr);
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end

            if (w_grant) begin
                r_sel_idx      <= r_ptr;
                r_sel_criterio <= r_min;
            end

            if (w_ack) begin
                r_last_idx <= r_sel_idx;
            end
        end
    end

    assign aa_atualizar_o = (r_estado == ST_CLASSIFY);
    assign sel_valid_o    = (r_estado == ST_GRANT);
    assign busy_o         = (r_estado != ST_IDLE);
    assign sel_idx_o      = r_sel_idx;
    assign sel_criterio_o = r_sel_criterio;
    assign vazio_o        = r_vazio;
    assign erro_o         = r_erro;

endmodule

// File: tb/tb_escalonador_ativos.sv
// Directed bench for escalonador_ativos: a table of rounds with hand-computed outcomes
// plus a hand-written reset-during-grant sequence.
module tb_escalonador_ativos;

    localparam int N  = 8;
    localparam int CW = 5;
    localparam int IW = 3;

    localparam logic [N*CW-1:0] CRIT_A = {5'd3, 5'd4, 5'd3, 5'd3, 5'd0, 5'd3, 5'd7, 5'd3};
    localparam logic [N*CW-1:0] CRIT_W = {5'd2, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd9, 5'd2};
    localparam logic [N-1:0]    ATV_A  = 8'b0010_0110;
    localparam logic [N-1:0]    ATV_W  = 8'b1000_0001;

    typedef enum int {EV_NONE, EV_GRANT, EV_VAZIO, EV_ERRO} ev_e;

    typedef struct {
        logic [N-1:0]    ativo;
        logic [N*CW-1:0] crit;
        int              p;
        logic [CW-1:0]   ca;
        int              hold;
        ev_e             kind;
        int              cyc;
        int              idx;
        int              crt;
    } vec_t;

    typedef struct {
        ev_e kind;
        int  cyc;
        int  idx;
        int  crt;
        int  aa_count;
        int  aa_cycle;
        int  busy_evt;
        int  stable;
        int  valid_after;
        int  busy_after;
    } obs_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_in = 1'b0;
    logic [N-1:0]    na_ativo_in = '0;
    logic [N*CW-1:0] na_criterio_in = '0;
    logic            ca_pronto_in = 1'b0;
    logic [CW-1:0]   ca_criterio_geral_in = '0;
    logic            sel_ack_in = 1'b0;
    logic            aa_atualizar_o;
    logic            sel_valid_o;
    logic [IW-1:0]   sel_idx_o;
    logic [CW-1:0]   sel_criterio_o;
    logic            vazio_o;
    logic            erro_o;
    logic            busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    escalonador_ativos #(.NUM_NA(N), .CRITERIO_WIDTH(CW)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start_in             (start_in),
        .na_ativo_in          (na_ativo_in),
        .na_criterio_in       (na_criterio_in),
        .ca_pronto_in         (ca_pronto_in),
        .ca_criterio_geral_in (ca_criterio_geral_in),
        .aa_atualizar_o       (aa_atualizar_o),
        .sel_valid_o          (sel_valid_o),
        .sel_idx_o            (sel_idx_o),
        .sel_criterio_o       (sel_criterio_o),
        .sel_ack_in           (sel_ack_in),
        .vazio_o              (vazio_o),
        .erro_o               (erro_o),
        .busy_o               (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, int'(sel_valid_o), 0);
        check({tag, "_idx"},   int'(sel_idx_o), 0);
        check({tag, "_crit"},  int'(sel_criterio_o), 0);
        check({tag, "_busy"},  int'(busy_o), 0);
        check({tag, "_aa"},    int'(aa_atualizar_o), 0);
        check({tag, "_vazio"}, int'(vazio_o), 0);
        check({tag, "_erro"},  int'(erro_o), 0);
    endtask

    // Start is driven in the current window (cycle 0); pronto is driven during cycle p.
    // hold < 0 leaves the round sitting in GRANT without acknowledging.
    task automatic run_round(input logic [N-1:0] ativo, input logic [N*CW-1:0] crit,
                             input int p, input logic [CW-1:0] ca, input int hold,
                             output obs_t o);
        o.kind = EV_NONE; o.cyc = -1; o.idx = -1; o.crt = -1;
        o.aa_count = 0; o.aa_cycle = -1; o.busy_evt = -1;
        o.stable = 1; o.valid_after = -1; o.busy_after = -1;
        na_ativo_in          = ativo;
        na_criterio_in       = crit;
        ca_criterio_geral_in = ca;
        start_in             = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            start_in     = 1'b0;
            ca_pronto_in = (c == p);
            if (aa_atualizar_o) begin
                o.aa_count++;
                o.aa_cycle = c;
            end
            if (vazio_o) begin
                o.kind = EV_VAZIO; o.cyc = c; o.busy_evt = int'(busy_o);
                break;
            end
            if (erro_o) begin
                o.kind = EV_ERRO; o.cyc = c; o.busy_evt = int'(busy_o);
                break;
            end
            if (sel_valid_o) begin
                o.kind = EV_GRANT; o.cyc = c; o.busy_evt = int'(busy_o);
                o.idx = int'(sel_idx_o); o.crt = int'(sel_criterio_o);
                ca_pronto_in = 1'b0;
                if (hold >= 0) begin
                    for (int h = 0; h < hold; h++) begin
                        start_in   = (h % 2 == 0);
                        sel_ack_in = 1'b0;
                        tick();
                        if (!sel_valid_o || int'(sel_idx_o) != o.idx ||
                            int'(sel_criterio_o) != o.crt)
                            o.stable = 0;
                    end
                    start_in   = 1'b0;
                    sel_ack_in = 1'b1;
                    tick();
                    sel_ack_in    = 1'b0;
                    o.valid_after = int'(sel_valid_o);
                    o.busy_after  = int'(busy_o);
                end
                break;
            end
        end
        ca_pronto_in = 1'b0;
        start_in     = 1'b0;
    endtask

    vec_t vecs[10];
    obs_t o;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{ATV_A, CRIT_A,  4, 5'd3, 0, EV_GRANT,  8, 2, 3};
        vecs[1] = '{ATV_A, CRIT_A,  3, 5'd3, 1, EV_GRANT,  7, 5, 3};
        vecs[2] = '{8'h00, CRIT_A,  3, 5'd3, 0, EV_VAZIO,  1, 0, 0};
        vecs[3] = '{ATV_A, CRIT_A, -1, 5'd3, 0, EV_ERRO,  17, 0, 0};
        vecs[4] = '{ATV_A, CRIT_A,  2, 5'd4, 0, EV_ERRO,  11, 0, 0};
        vecs[5] = '{ATV_A, CRIT_A,  2, 5'd3, 5, EV_GRANT,  8, 2, 3};
        vecs[6] = '{ATV_A, CRIT_A,  1, 5'd3, 0, EV_ERRO,  17, 0, 0};
        vecs[7] = '{ATV_W, CRIT_W,  5, 5'd2, 2, EV_GRANT, 11, 7, 2};
        vecs[8] = '{ATV_W, CRIT_W,  2, 5'd2, 0, EV_GRANT,  4, 0, 2};
        vecs[9] = '{ATV_A, CRIT_A,  2, 5'd3, 0, EV_GRANT,  5, 2, 3};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_round(vecs[i].ativo, vecs[i].crit, vecs[i].p, vecs[i].ca, vecs[i].hold, o);
            check($sformatf("v%0d_kind", i), int'(o.kind), int'(vecs[i].kind));
            check($sformatf("v%0d_cycle", i), o.cyc, vecs[i].cyc);
            check($sformatf("v%0d_busy_evt", i), o.busy_evt,
                  (vecs[i].kind == EV_GRANT) ? 1 : 0);
            check($sformatf("v%0d_aa_count", i), o.aa_count,
                  (vecs[i].kind == EV_VAZIO) ? 0 : 1);
            if (vecs[i].kind != EV_VAZIO)
                check($sformatf("v%0d_aa_cycle", i), o.aa_cycle, 1);
            if (vecs[i].kind == EV_GRANT) begin
                check($sformatf("v%0d_idx", i), o.idx, vecs[i].idx);
                check($sformatf("v%0d_crit", i), o.crt, vecs[i].crt);
                check($sformatf("v%0d_stable", i), o.stable, 1);
                check($sformatf("v%0d_valid_after_ack", i), o.valid_after, 0);
                check($sformatf("v%0d_busy_after_ack", i), o.busy_after, 0);
            end
        end

        // last_idx is now 2, so this round grants node 5 and is left pending.
        run_round(ATV_A, CRIT_A, 2, 5'd3, -1, o);
        check("pend_kind", int'(o.kind), int'(EV_GRANT));
        check("pend_idx", o.idx, 5);
        check("pend_cycle", o.cyc, 6);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();

        // last_idx back to NUM_NA-1: scan from node 0 reaches node 2 at offset 2.
        run_round(ATV_A, CRIT_A, 2, 5'd3, 0, o);
        check("post_rst_kind", int'(o.kind), int'(EV_GRANT));
        check("post_rst_idx", o.idx, 2);
        check("post_rst_cycle", o.cyc, 6);
        check("post_rst_valid_after_ack", o.valid_after, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/escalonador_ativos.md
# escalonador_ativos

Sequencing controller for the active-node minimum-criterion classifier (`classificar_ativo`). On a start request it launches a classification round, waits for the classifier's done pulse and watches for a stalled round. It then locates which active node holds the minimum criterion, breaking ties round-robin, and presents that node to the downstream expansion stage with a valid/ack handshake. It sits between the node-state storage and the expansion logic of the path-search datapath.

## Interface
- `NUM_NA`, 8: number of node slots; must be ≥ 2.
- `CRITERIO_WIDTH`, 5: criterion width in bits.
- `IDX_WIDTH`, `$clog2(NUM_NA)`: node index width.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_in`  in  1  request one selection round; sampled only in IDLE.
- `na_ativo_in`  in  NUM_NA  active flag per node.
- `na_criterio_in`  in  NUM_NA*CRITERIO_WIDTH  packed criteria; node i occupies bits [CRITERIO_WIDTH*i +: CRITERIO_WIDTH].
- `ca_pronto_in`  in  1  classifier done pulse.
- `ca_criterio_geral_in`  in  CRITERIO_WIDTH  classifier minimum.
- `aa_atualizar_o`  out  1  one-cycle pulse that starts the classifier.
- `sel_valid_o`  out  1  selection valid; held high until acknowledged.
- `sel_idx_o`  out  IDX_WIDTH  selected node index.
- `sel_criterio_o`  out  CRITERIO_WIDTH  criterion of the selected node.
- `sel_ack_in`  in  1  consumer accepts the selection.
- `vazio_o`  out  1  one-cycle pulse: no active node.
- `erro_o`  out  1  one-cycle pulse: watchdog expired or scan found no match.
- `busy_o`  out  1  high when the FSM is not in IDLE.

## Operation
- FSM states: IDLE, CLASSIFY, WAIT_PRONTO, SCAN, GRANT.
- IDLE:
  - `start_in`=1 and `na_ativo_in`==0: pulse `vazio_o`, stay in IDLE.
  - `start_in`=1 otherwise: go to CLASSIFY.
  - `start_in` is ignored in every other state.
- CLASSIFY:
  - Assert `aa_atualizar_o` for exactly one cycle.
  - Clear the watchdog counter.
  - Go to WAIT_PRONTO.
- WAIT_PRONTO:
  - Watchdog increments each cycle.
  - `ca_pronto_in`=1: latch `ca_criterio_geral_in` into `min_r`, load `ptr` = (`last_idx`+1) mod NUM_NA, clear the scan counter, go to SCAN.
  - Watchdog reaches 2*NUM_NA−1 without `ca_pronto_in`: pulse `erro_o`, go to IDLE.
- SCAN (one node per cycle):
  - Match when `na_ativo_in[ptr]` and `na_criterio_in[ptr]`==`min_r`: latch `sel_idx_o`=`ptr` and `sel_criterio_o`=`min_r`, go to GRANT.
  - No match: `ptr` wraps mod NUM_NA and the scan counter increments.
  - After NUM_NA checks with no match: pulse `erro_o`, go to IDLE. This covers inputs that changed during the round.
- GRANT:
  - `sel_valid_o`=1 with stable index and criterion.
  - On `sel_ack_in`=1: `last_idx` ← `sel_idx_o`, go to IDLE.
- `last_idx` is updated only on an acknowledged grant. Tie-break: the first match at or after `last_idx`+1 wins.
- `na_ativo_in` and `na_criterio_in` must be stable from start until grant, vazio, or erro.
- Arithmetic:
  - Criteria are compared as unsigned equality.
  - Pointer wrap uses explicit compare-to-(NUM_NA−1), not power-of-two truncation.
  - The watchdog counter is $clog2(2*NUM_NA) bits wide.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, except `sel_idx_o`=0 and `sel_criterio_o`=0.
  - `last_idx`=NUM_NA−1, so the first scan begins at node 0.
  - `min_r`=all-ones.
- Round latency, with start sampled at cycle 0:
  - `aa_atualizar_o` high in cycle 1.
  - `ca_pronto_in` arrives at cycle P.
  - First SCAN check at P+1.
  - A match at scan offset k gives `sel_valid_o` high from cycle P+k+2.
- `vazio_o` is high in cycle 1 when start is sampled with no active node.
- `ca_pronto_in` is ignored outside WAIT_PRONTO. A pulse coincident with `aa_atualizar_o` is dropped.
- Ack handling:
  - Ack sampled high in cycle g: `sel_valid_o` is low in g+1 and `busy_o` is low in g+1.
  - A new start is accepted in g+1 at the earliest.
- Watchdog: with no pronto, `erro_o` pulses in cycle 2*NUM_NA+1 after the start cycle.
- Reset asserted mid-round: immediate return to reset values.
  - `last_idx` resets as well.
  - A pending grant is lost without notification.

## Structure
- Shared package `escalonador_pkg`:
  - State encoding enum.
  - Default localparams for NUM_NA and CRITERIO_WIDTH.
  - Watchdog limit expression 2*NUM_NA−1.
- Single module, no sub-module required. The classifier is instantiated alongside it by the parent.
- Criterion unpacking uses a generate loop to a 2D array, indexed by `ptr`.

## Test plan
- Tie-break, first round after reset: NUM_NA=8, ativo=8'b0010_0110, criteria n1=7, n2=3, n5=3, behavioural classifier returns 3 → `sel_idx_o`=2, `sel_criterio_o`=3. After ack, repeat the round → `sel_idx_o`=5.
- Empty: ativo=0, start → `vazio_o` in cycle 1; `aa_atualizar_o` never asserted; `busy_o` stays 0.
- Watchdog: start with the classifier never pulsing pronto → `erro_o` in cycle 17; FSM back in IDLE; no valid.
- Scan miss: classifier returns 4, but no active node has criterion 4 → `erro_o` after 8 scan cycles; `last_idx` unchanged.
- Handshake: hold ack low for 5 cycles → `sel_valid_o`, index and criterion stay stable. Toggling `start_in` meanwhile has no effect.
- Reset mid-GRANT: assert `rst_n`=0 → all outputs 0 immediately. The next round picks node 2 again, because `last_idx` was reset.
